// File: rtl/router_decap_ctrl.sv
// Receive-side decapsulation controller: pops Aurora words, parses the header and
// writes local payloads to memory, forwards transit packets or drains bad ones.
// Optional saturating drop counter is enabled by defining DECAP_DROP_CNT_EN.
module router_decap_ctrl #(
   parameter int AURORA_DATA_WIDTH      = 64,
   parameter int ADDR_WIDTH             = 10,
   parameter int NUMBER_PACKET          = 19,
   parameter int RECOGNIZE_ROUTER_WIDTH = 2,
   parameter int ROUTER_ID              = 0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         rx_empty,
   output logic                         rx_rd,
   input  logic [AURORA_DATA_WIDTH-1:0] rx_data,
   output logic                         arbiter_write_req,
   input  logic                         arbiter_write_gnt,
   output logic [ADDR_WIDTH-1:0]        arbiter_dst_addr,
   output logic                         mem_we,
   output logic [ADDR_WIDTH-1:0]        mem_addr,
   output logic [AURORA_DATA_WIDTH-1:0] mem_wdata,
   input  logic                         fwd_afull,
   output logic                         fwd_we,
   output logic [AURORA_DATA_WIDTH-1:0] fwd_data,
   output logic [8:0]                   header_pkt_recv,
   output logic                         decap_done,
   output logic                         pkt_drop
`ifdef DECAP_DROP_CNT_EN
   ,
   input  logic                         drop_cnt_clr,
   output logic [7:0]                   drop_cnt
`endif
);

   localparam int CNT_W    = 6;
   localparam int TTL_LSB  = 62;
   localparam int PKTN_LSB = 57;
   localparam int SRC_LSB  = 55;
   localparam int DST_LSB  = 53;
   localparam int LEN_LSB  = 48;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_ARB,
      S_LOCAL,
      S_FWD_HDR,
      S_FWD,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t                         state, next_state;
   logic                           armed;
   logic                           pop_d;
   logic [CNT_W-1:0]               issued;
   logic [CNT_W-1:0]               written;
   logic [CNT_W-1:0]               len_q;
   logic [ADDR_WIDTH-1:0]          dst_addr_q;
   logic [AURORA_DATA_WIDTH-1:0]   hdr_fwd_q;
   logic                           drop_q;

   logic [1:0]                     hdr_ttl;
   logic [1:0]                     hdr_ttl_dec;
   logic [RECOGNIZE_ROUTER_WIDTH-1:0] hdr_dst;
   logic [CNT_W-1:0]               hdr_len;
   logic                           hdr_bad;
   logic                           hdr_local;
   logic                           hdr_drop;
   logic                           more_to_pop;
   logic                           payload_we;
   logic                           last_write;

   // Header fields are only meaningful while in S_HDR, the cycle after the pop.
   assign hdr_ttl     = rx_data[TTL_LSB +: 2];
   assign hdr_ttl_dec = hdr_ttl - 2'd1;
   assign hdr_dst     = rx_data[DST_LSB +: RECOGNIZE_ROUTER_WIDTH];
   assign hdr_len     = {1'b0, rx_data[LEN_LSB +: 5]};
   assign hdr_bad     = (hdr_len == '0) || (hdr_len > CNT_W'(NUMBER_PACKET));
   assign hdr_local   = (hdr_dst == RECOGNIZE_ROUTER_WIDTH'(ROUTER_ID));
   assign hdr_drop    = hdr_bad || (!hdr_local && (hdr_ttl == 2'd0));

   assign more_to_pop = (issued < len_q);
   assign payload_we  = pop_d && ((state == S_LOCAL) || (state == S_FWD));
   assign last_write  = payload_we && (written == (len_q - CNT_W'(1)));

   always_comb begin
      // NOTE: defaults first, so no branch below can leave a signal unassigned and infer a latch.
      next_state = state;
      rx_rd      = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (armed && !rx_empty) begin
               rx_rd      = 1'b1;
               next_state = S_HDR;
            end
         end
         S_HDR: begin
            if (hdr_drop)       next_state = S_DRAIN;
            else if (hdr_local) next_state = S_ARB;
            else                next_state = S_FWD_HDR;
         end
         S_ARB: begin
            if (arbiter_write_gnt) next_state = S_LOCAL;
         end
         S_LOCAL: begin
            rx_rd = !rx_empty && arbiter_write_gnt && more_to_pop;
            if (last_write) next_state = S_DONE;
         end
         S_FWD_HDR: begin
            next_state = S_FWD;
         end
         S_FWD: begin
            rx_rd = !rx_empty && !fwd_afull && more_to_pop;
            if (last_write) next_state = S_DONE;
         end
         S_DRAIN: begin
            rx_rd = !rx_empty && more_to_pop;
            if (!more_to_pop) next_state = S_DONE;
         end
         S_DONE: begin
            next_state = S_IDLE;
         end
         default: next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= S_IDLE;
         armed           <= 1'b0;
         pop_d           <= 1'b0;
         issued          <= '0;
         written         <= '0;
         len_q           <= '0;
         dst_addr_q      <= '0;
         hdr_fwd_q       <= '0;
         drop_q          <= 1'b0;
         header_pkt_recv <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
         state <= next_state;
         armed <= 1'b1;
         pop_d <= rx_rd;
         if (state == S_HDR) begin
            len_q           <= hdr_len;
            dst_addr_q      <= rx_data[ADDR_WIDTH-1:0];
            hdr_fwd_q       <= {hdr_ttl_dec, rx_data[TTL_LSB-1:0]};
            drop_q          <= hdr_drop;
            header_pkt_recv <= {rx_data[TTL_LSB +: 2], rx_data[PKTN_LSB +: 5], rx_data[SRC_LSB +: 2]};
            issued          <= '0;
            written         <= '0;
         end else begin
            if (rx_rd)      issued  <= issued + CNT_W'(1);
            if (payload_we) written <= written + CNT_W'(1);
         end
      end
   end

   // Data outputs are gated to zero whenever their strobe is low.
   assign arbiter_write_req = (state == S_ARB) || (state == S_LOCAL);
   assign arbiter_dst_addr  = arbiter_write_req ? dst_addr_q : '0;

   assign mem_we    = pop_d && (state == S_LOCAL);
   assign mem_addr  = mem_we ? (dst_addr_q + ADDR_WIDTH'(written)) : '0;
   assign mem_wdata = mem_we ? rx_data : '0;

   assign fwd_we   = (state == S_FWD_HDR) || (pop_d && (state == S_FWD));
   assign fwd_data = (state == S_FWD_HDR) ? hdr_fwd_q : (fwd_we ? rx_data : '0);

   assign decap_done = (state == S_DONE);
   assign pkt_drop   = (state == S_DONE) && drop_q;

`ifdef DECAP_DROP_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_cnt <= '0;
      end else if (drop_cnt_clr) begin
         drop_cnt <= '0;
      end else if (pkt_drop && (drop_cnt != 8'hFF)) begin
         drop_cnt <= drop_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_router_decap_ctrl.sv
// Self-checking bench for router_decap_ctrl: FIFO model feeding rx, scoreboard queues
// for memory writes, egress words and packet-end events.
module tb_router_decap_ctrl;

   typedef struct packed {
      logic [9:0]  addr;
      logic [63:0] data;
   } mem_exp_t;

   typedef enum int {K_LOCAL, K_FWD, K_DROP} kind_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rx_empty = 1'b1;
   logic        rx_rd;
   logic [63:0] rx_data = '0;
   logic        arbiter_write_req;
   logic        arbiter_write_gnt = 1'b0;
   logic [9:0]  arbiter_dst_addr;
   logic        mem_we;
   logic [9:0]  mem_addr;
   logic [63:0] mem_wdata;
   logic        fwd_afull = 1'b0;
   logic        fwd_we;
   logic [63:0] fwd_data;
   logic [8:0]  header_pkt_recv;
   logic        decap_done;
   logic        pkt_drop;
`ifdef DECAP_DROP_CNT_EN
   logic        drop_cnt_clr = 1'b0;
   logic [7:0]  drop_cnt;
`endif

   logic [63:0] rx_q[$];
   mem_exp_t    exp_mem[$];
   logic [63:0] exp_fwd[$];
   kind_t       exp_done[$];

   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   pops = 0;
   int   last_mem_cyc = 0;
   int   last_fwd_cyc = 0;
   int   mem_seen = 0;
   int   fwd_seen = 0;
   bit   stall_en = 1'b0;
   bit   stall_phase = 1'b0;
   logic [8:0] exp_hrec = '0;

   router_decap_ctrl dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .rx_empty          (rx_empty),
      .rx_rd             (rx_rd),
      .rx_data           (rx_data),
      .arbiter_write_req (arbiter_write_req),
      .arbiter_write_gnt (arbiter_write_gnt),
      .arbiter_dst_addr  (arbiter_dst_addr),
      .mem_we            (mem_we),
      .mem_addr          (mem_addr),
      .mem_wdata         (mem_wdata),
      .fwd_afull         (fwd_afull),
      .fwd_we            (fwd_we),
      .fwd_data          (fwd_data),
      .header_pkt_recv   (header_pkt_recv),
      .decap_done        (decap_done),
      .pkt_drop          (pkt_drop)
`ifdef DECAP_DROP_CNT_EN
      ,
      .drop_cnt_clr      (drop_cnt_clr),
      .drop_cnt          (drop_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Receive FIFO model: data appears the cycle after a pop; empty flag refreshed each edge.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rx_rd && (rx_q.size() > 0)) begin
         rx_data <= rx_q.pop_front();
         pops    <= pops + 1;
      end
      stall_phase <= ~stall_phase;
      rx_empty    <= (rx_q.size() == 0) || (stall_en && !stall_phase);
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time exceeded, required completion");
      $fatal(1, "watchdog");
   end

   // One cycle of monitoring, sampled on the falling edge.
   task automatic tick();
      mem_exp_t e;
      kind_t    k;
      @(negedge clk);
      if (rx_rd) begin
         n_cmp++;
         if (rx_empty) begin
            n_err++;
            $display("FAIL rx_rd_when_empty: rx_rd=1 rx_empty=1 at cycle %0d, required rx_rd=0", cyc);
         end
      end
      if (mem_we) begin
         mem_seen++;
         n_cmp++;
         if (exp_mem.size() == 0) begin
            n_err++;
            $display("FAIL mem_write: got addr %h data %h, required no write", mem_addr, mem_wdata);
         end else begin
            e = exp_mem.pop_front();
            if ({mem_addr, mem_wdata} !== e) begin
               n_err++;
               $display("FAIL mem_write: got addr %h data %h, required addr %h data %h",
                        mem_addr, mem_wdata, e.addr, e.data);
            end
         end
         last_mem_cyc = cyc;
      end
      if (fwd_we) begin
         fwd_seen++;
         n_cmp++;
         if (exp_fwd.size() == 0) begin
            n_err++;
            $display("FAIL fwd_write: got %h, required no write", fwd_data);
         end else if (fwd_data !== exp_fwd[0]) begin
            n_err++;
            $display("FAIL fwd_write: got %h, required %h", fwd_data, exp_fwd[0]);
            void'(exp_fwd.pop_front());
         end else begin
            void'(exp_fwd.pop_front());
         end
         last_fwd_cyc = cyc;
      end
      if (pkt_drop && !decap_done) begin
         n_cmp++;
         n_err++;
         $display("FAIL drop_without_done: pkt_drop=1 decap_done=0, required coincident");
      end
      if (decap_done) begin
         n_cmp++;
         if (exp_done.size() == 0) begin
            n_err++;
            $display("FAIL decap_done: got unexpected pulse, required none");
         end else begin
            k = exp_done.pop_front();
            if (pkt_drop !== (k == K_DROP)) begin
               n_err++;
               $display("FAIL pkt_drop: got %b, required %b", pkt_drop, (k == K_DROP));
            end
            if ((k == K_LOCAL) && (cyc != last_mem_cyc + 1)) begin
               n_err++;
               $display("FAIL done_latency_local: got %0d cycles after last write, required 1", cyc - last_mem_cyc);
            end
            if ((k == K_FWD) && (cyc != last_fwd_cyc + 1)) begin
               n_err++;
               $display("FAIL done_latency_fwd: got %0d cycles after last word, required 1", cyc - last_fwd_cyc);
            end
            if (arbiter_write_req !== 1'b0) begin
               n_err++;
               $display("FAIL req_in_done: got arbiter_write_req=%b, required 0", arbiter_write_req);
            end
         end
      end
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n;
      n = 0;
      while ((exp_done.size() != 0) && (n < budget)) begin
         tick();
         n++;
      end
      n_cmp++;
      if ((exp_done.size() != 0) || (exp_mem.size() != 0) || (exp_fwd.size() != 0)) begin
         n_err++;
         $display("FAIL %s_complete: pending done=%0d mem=%0d fwd=%0d after %0d cycles, required 0/0/0",
                  name, exp_done.size(), exp_mem.size(), exp_fwd.size(), n);
         exp_done.delete();
         exp_mem.delete();
         exp_fwd.delete();
      end
   endtask

   // Pushes a packet into the FIFO and the outcome the spec predicts into the scoreboards.
   task automatic send_pkt(input logic [1:0] ttl, input logic [4:0] num, input logic [1:0] src,
                           input logic [1:0] dst, input logic [4:0] len, input logic [9:0] addr);
      logic [63:0] hdr;
      logic [63:0] w;
      logic [63:0] fh;
      bit          bad;
      kind_t       k;
      hdr          = '0;
      hdr[63:62]   = ttl;
      hdr[61:57]   = num;
      hdr[56:55]   = src;
      hdr[54:53]   = dst;
      hdr[52:48]   = len;
      hdr[9:0]     = addr;
      bad          = (len == 5'd0) || (len > 5'd19);
      if (bad)               k = K_DROP;
      else if (dst == 2'd0)  k = K_LOCAL;
      else if (ttl == 2'd0)  k = K_DROP;
      else                   k = K_FWD;
      rx_q.push_back(hdr);
      if (k == K_FWD) begin
         fh        = hdr;
         fh[63:62] = ttl - 2'd1;
         exp_fwd.push_back(fh);
      end
      for (int i = 0; i < int'(len); i++) begin
         w = {$urandom, $urandom};
         rx_q.push_back(w);
         if (k == K_LOCAL) exp_mem.push_back('{addr: addr + 10'(i), data: w});
         if (k == K_FWD)   exp_fwd.push_back(w);
      end
      exp_done.push_back(k);
      exp_hrec = {ttl, num, src};
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      n_cmp++;
      if ({rx_rd, arbiter_write_req, mem_we, fwd_we, decap_done, pkt_drop} !== 6'b0) begin
         n_err++;
         $display("FAIL reset_ctrl: got %b, required 000000",
                  {rx_rd, arbiter_write_req, mem_we, fwd_we, decap_done, pkt_drop});
      end
      n_cmp++;
      if ({arbiter_dst_addr, mem_addr, mem_wdata, fwd_data} !== '0) begin
         n_err++;
         $display("FAIL reset_data: got %h %h %h %h, required all 0", arbiter_dst_addr, mem_addr, mem_wdata, fwd_data);
      end
      n_cmp++;
      if (header_pkt_recv !== 9'd0) begin
         n_err++;
         $display("FAIL reset_hdr: got %h, required 000", header_pkt_recv);
      end
`ifdef DECAP_DROP_CNT_EN
      n_cmp++;
      if (drop_cnt !== 8'd0) begin
         n_err++;
         $display("FAIL reset_drop_cnt: got %0d, required 0", drop_cnt);
      end
`endif
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_local();
      arbiter_write_gnt = 1'b1;
      send_pkt(2'd3, 5'd7, 2'd1, 2'd0, 5'd4, 10'h3FE);
      wait_idle("local", 60);
      n_cmp++;
      if (header_pkt_recv !== exp_hrec) begin
         n_err++;
         $display("FAIL local_hdr: got %h, required %h", header_pkt_recv, exp_hrec);
      end
      tick();
      n_cmp++;
      if (arbiter_write_req !== 1'b0) begin
         n_err++;
         $display("FAIL local_req_after_done: got %b, required 0", arbiter_write_req);
      end
   endtask

   task automatic test_forward();
      int base;
      int n;
      base = fwd_seen;
      n    = 0;
      send_pkt(2'd2, 5'd12, 2'd3, 2'd2, 5'd3, 10'h055);
      while ((fwd_seen < base + 2) && (n < 60)) begin
         tick();
         n++;
      end
      fwd_afull = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_cmp++;
         if (rx_rd !== 1'b0) begin
            n_err++;
            $display("FAIL fwd_afull_pause: got rx_rd=%b, required 0", rx_rd);
         end
      end
      fwd_afull = 1'b0;
      wait_idle("forward", 60);
      n_cmp++;
      if (header_pkt_recv !== exp_hrec) begin
         n_err++;
         $display("FAIL fwd_hdr: got %h, required %h", header_pkt_recv, exp_hrec);
      end
   endtask

   task automatic test_expired();
      int base;
      base = pops;
      send_pkt(2'd0, 5'd3, 2'd2, 2'd1, 5'd5, 10'h010);
      wait_idle("expired", 60);
      n_cmp++;
      if (pops - base !== 6) begin
         n_err++;
         $display("FAIL expired_pops: got %0d, required 6", pops - base);
      end
`ifdef DECAP_DROP_CNT_EN
      n_cmp++;
      if (drop_cnt !== 8'd1) begin
         n_err++;
         $display("FAIL expired_drop_cnt: got %0d, required 1", drop_cnt);
      end
`endif
   endtask

   task automatic test_malformed();
      int base;
      base = pops;
      send_pkt(2'd1, 5'd1, 2'd0, 2'd0, 5'd0, 10'h020);
      wait_idle("malformed0", 40);
      n_cmp++;
      if (pops - base !== 1) begin
         n_err++;
         $display("FAIL malformed0_pops: got %0d, required 1", pops - base);
      end
      base = pops;
      send_pkt(2'd3, 5'd2, 2'd1, 2'd0, 5'd25, 10'h030);
      wait_idle("malformed25", 100);
      n_cmp++;
      if (pops - base !== 26) begin
         n_err++;
         $display("FAIL malformed25_pops: got %0d, required 26", pops - base);
      end
      n_cmp++;
      if (header_pkt_recv !== exp_hrec) begin
         n_err++;
         $display("FAIL malformed_hdr: got %h, required %h", header_pkt_recv, exp_hrec);
      end
`ifdef DECAP_DROP_CNT_EN
      n_cmp++;
      if (drop_cnt !== 8'd3) begin
         n_err++;
         $display("FAIL malformed_drop_cnt: got %0d, required 3", drop_cnt);
      end
      drop_cnt_clr = 1'b1;
      tick();
      drop_cnt_clr = 1'b0;
      tick();
      n_cmp++;
      if (drop_cnt !== 8'd0) begin
         n_err++;
         $display("FAIL drop_cnt_clr: got %0d, required 0", drop_cnt);
      end
`endif
   endtask

   task automatic test_stalls();
      int n;
      int seen;
      arbiter_write_gnt = 1'b0;
      stall_en          = 1'b1;
      send_pkt(2'd1, 5'd31, 2'd2, 2'd0, 5'd19, 10'h3F5);
      n = 0;
      while (!arbiter_write_req && (n < 100)) begin
         tick();
         n++;
      end
      seen = mem_seen;
      repeat (7) tick();
      n_cmp++;
      if (mem_seen !== seen) begin
         n_err++;
         $display("FAIL stall_write_before_gnt: got %0d writes, required 0", mem_seen - seen);
      end
      arbiter_write_gnt = 1'b1;
      wait_idle("stalls", 200);
      n_cmp++;
      if (mem_seen - seen !== 19) begin
         n_err++;
         $display("FAIL stall_write_count: got %0d, required 19", mem_seen - seen);
      end
      n_cmp++;
      if (header_pkt_recv !== exp_hrec) begin
         n_err++;
         $display("FAIL stall_hdr: got %h, required %h", header_pkt_recv, exp_hrec);
      end
      stall_en = 1'b0;
   endtask

   task automatic test_reset_mid();
      int n;
      int seen;
      arbiter_write_gnt = 1'b1;
      seen = mem_seen;
      n    = 0;
      send_pkt(2'd2, 5'd9, 2'd3, 2'd0, 5'd8, 10'h200);
      while ((mem_seen < seen + 2) && (n < 60)) begin
         tick();
         n++;
      end
      #1 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({rx_rd, arbiter_write_req, mem_we, fwd_we, decap_done, pkt_drop, header_pkt_recv,
           arbiter_dst_addr, mem_addr, mem_wdata, fwd_data} !== '0) begin
         n_err++;
         $display("FAIL reset_mid_outputs: got ctrl %b hdr %h addr %h, required all 0",
                  {rx_rd, arbiter_write_req, mem_we, fwd_we, decap_done, pkt_drop}, header_pkt_recv, mem_addr);
      end
      rx_q.delete();
      exp_mem.delete();
      exp_fwd.delete();
      exp_done.delete();
      repeat (2) tick();
      rst_n = 1'b1;
      send_pkt(2'd1, 5'd4, 2'd2, 2'd0, 5'd3, 10'h100);
      wait_idle("after_reset", 60);
      n_cmp++;
      if (header_pkt_recv !== exp_hrec) begin
         n_err++;
         $display("FAIL after_reset_hdr: got %h, required %h", header_pkt_recv, exp_hrec);
      end
   endtask

   task automatic test_back_to_back();
      send_pkt(2'd3, 5'd5, 2'd0, 2'd0, 5'd2, 10'h0F0);
      send_pkt(2'd3, 5'd6, 2'd1, 2'd3, 5'd5, 10'h000);
      send_pkt(2'd2, 5'd8, 2'd2, 2'd1, 5'd0, 10'h000);
      wait_idle("back_to_back", 120);
      n_cmp++;
      if (header_pkt_recv !== exp_hrec) begin
         n_err++;
         $display("FAIL b2b_hdr: got %h, required %h", header_pkt_recv, exp_hrec);
      end
   endtask

   initial begin
      test_reset();
      test_local();
      test_forward();
      test_expired();
      test_malformed();
      test_stalls();
      test_reset_mid();
      test_back_to_back();
      repeat (3) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
